// File: rtl/cmp_result_tracker.sv
// Purpose: tracks the outcomes of a magnitude comparator (lt/eq/gt flags).
//   It keeps a saturating count of each legal outcome and of illegal flag
//   combinations, remembers the last legal result, and runs a small FSM.
//   The FSM locks after LOCK_N consecutive equal samples and latches ERROR
//   on any illegal sample.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid                   comparator flags are valid this cycle
//   a_lt_b, a_eq_b, a_gt_b     comparator flags (legal when exactly one is set)
//   clr                        synchronous clear, wins over a same-cycle sample
//   lt_cnt/eq_cnt/gt_cnt       saturating counts of legal outcomes
//   err_cnt                    saturating count of illegal samples
//   last_res                   last legal result: 00 none, 01 lt, 10 eq, 11 gt
//   state                      00 IDLE, 01 TRACK, 10 LOCKED, 11 ERROR
//   lock, err_flag             registered state decodes for LOCKED / ERROR
module cmp_result_tracker #(
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned LOCK_N = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             a_lt_b,
  input  logic             a_eq_b,
  input  logic             a_gt_b,
  input  logic             clr,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [1:0]       last_res,
  output logic [1:0]       state,
  output logic             lock,
  output logic             err_flag
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_TRACK  = 2'b01,
    S_LOCKED = 2'b10,
    S_ERROR  = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] LOCK_V  = CNT_W'(LOCK_N);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_LT   = 2'b01;
  localparam logic [1:0] RES_EQ   = 2'b10;
  localparam logic [1:0] RES_GT   = 2'b11;

  logic [CNT_W-1:0] r_lt_cnt, r_eq_cnt, r_gt_cnt, r_err_cnt, r_streak;
  logic [1:0]       r_last_res;
  state_t           r_state;
  logic             r_lock, r_err_flag;

  logic [2:0] w_flags;
  logic       w_legal;
  logic       w_lock_hit;

  // Flag decode: a legal sample is strictly one-hot.
  assign w_flags    = {a_lt_b, a_eq_b, a_gt_b};
  assign w_legal    = (w_flags == 3'b100) || (w_flags == 3'b010) || (w_flags == 3'b001);
  // True when one more eq reaches LOCK_N (or the streak is already saturated there).
  assign w_lock_hit = (r_streak >= (LOCK_V - ONE));

  // Counters, last result, streak and FSM with registered state decodes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lt_cnt   <= '0;
      r_eq_cnt   <= '0;
      r_gt_cnt   <= '0;
      r_err_cnt  <= '0;
      r_streak   <= '0;
      r_last_res <= RES_NONE;
      r_state    <= S_IDLE;
      r_lock     <= 1'b0;
      r_err_flag <= 1'b0;
    end else if (clr) begin
      r_lt_cnt   <= '0;
      r_eq_cnt   <= '0;
      r_gt_cnt   <= '0;
      r_err_cnt  <= '0;
      r_streak   <= '0;
      r_last_res <= RES_NONE;
      r_state    <= S_IDLE;
      r_lock     <= 1'b0;
      r_err_flag <= 1'b0;
    end else if (in_valid) begin
      if (w_legal) begin
        if (a_lt_b) begin
          r_last_res <= RES_LT;
          if (r_lt_cnt != CNT_MAX) r_lt_cnt <= r_lt_cnt + ONE;
        end else if (a_eq_b) begin
          r_last_res <= RES_EQ;
          if (r_eq_cnt != CNT_MAX) r_eq_cnt <= r_eq_cnt + ONE;
        end else begin
          r_last_res <= RES_GT;
          if (r_gt_cnt != CNT_MAX) r_gt_cnt <= r_gt_cnt + ONE;
        end

        case (r_state)
          // ERROR is sticky; legal samples only update counters and last_res.
          S_ERROR: r_streak <= '0;
          default: begin
            if (a_eq_b) begin
              if (r_streak != LOCK_V) r_streak <= r_streak + ONE;
              if (w_lock_hit) begin
                r_state <= S_LOCKED;
                r_lock  <= 1'b1;
              end else begin
                r_state <= S_TRACK;
                r_lock  <= 1'b0;
              end
            end else begin
              r_streak <= '0;
              r_state  <= S_TRACK;
              r_lock   <= 1'b0;
            end
          end
        endcase
      end else begin
        if (r_err_cnt != CNT_MAX) r_err_cnt <= r_err_cnt + ONE;
        r_streak   <= '0;
        r_state    <= S_ERROR;
        r_lock     <= 1'b0;
        r_err_flag <= 1'b1;
      end
    end
  end

  assign lt_cnt   = r_lt_cnt;
  assign eq_cnt   = r_eq_cnt;
  assign gt_cnt   = r_gt_cnt;
  assign err_cnt  = r_err_cnt;
  assign last_res = r_last_res;
  assign state    = r_state;
  assign lock     = r_lock;
  assign err_flag = r_err_flag;

endmodule

// File: tb/tb_cmp_result_tracker.sv
// Directed bench for cmp_result_tracker (CNT_W=8, LOCK_N=4).
module tb_cmp_result_tracker;

  logic       clk;
  logic       rst_n;
  logic       in_valid, a_lt_b, a_eq_b, a_gt_b, clr;
  logic [7:0] lt_cnt, eq_cnt, gt_cnt, err_cnt;
  logic [1:0] last_res, state;
  logic       lock, err_flag;

  int n_tests;
  int n_fail;

  cmp_result_tracker #(.CNT_W(8), .LOCK_N(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .a_lt_b   (a_lt_b),
    .a_eq_b   (a_eq_b),
    .a_gt_b   (a_gt_b),
    .clr      (clr),
    .lt_cnt   (lt_cnt),
    .eq_cnt   (eq_cnt),
    .gt_cnt   (gt_cnt),
    .err_cnt  (err_cnt),
    .last_res (last_res),
    .state    (state),
    .lock     (lock),
    .err_flag (err_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one cycle of inputs, clock it, then return to idle and settle.
  task automatic cyc(input logic v, input logic lt, input logic eq,
                     input logic gt, input logic c);
    in_valid = v; a_lt_b = lt; a_eq_b = eq; a_gt_b = gt; clr = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0; a_lt_b = 1'b0; a_eq_b = 1'b0; a_gt_b = 1'b0; clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; a_lt_b = 1'b0; a_eq_b = 1'b0; a_gt_b = 1'b0; clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({lt_cnt, eq_cnt, gt_cnt, err_cnt} !== 32'h0) begin
      n_fail++; $display("FAIL reset_counts got %h exp 0", {lt_cnt, eq_cnt, gt_cnt, err_cnt});
    end
    n_tests++;
    if ({last_res, state, lock, err_flag} !== 6'b0) begin
      n_fail++; $display("FAIL reset_state got %b exp 000000", {last_res, state, lock, err_flag});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    cyc(1, 1, 0, 0, 0);
    n_tests++;
    if (last_res !== 2'b01 || state !== 2'b01) begin
      n_fail++; $display("FAIL basic_first_lt got res=%b st=%b exp res=01 st=01", last_res, state);
    end
    cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 0, 1, 0);
    n_tests++;
    if (lt_cnt !== 8'd1 || eq_cnt !== 8'd1 || gt_cnt !== 8'd1 || err_cnt !== 8'd0) begin
      n_fail++; $display("FAIL basic_counts got %0d/%0d/%0d/%0d exp 1/1/1/0", lt_cnt, eq_cnt, gt_cnt, err_cnt);
    end
    n_tests++;
    if (last_res !== 2'b11 || state !== 2'b01 || lock !== 1'b0) begin
      n_fail++; $display("FAIL basic_state got res=%b st=%b lock=%b exp res=11 st=01 lock=0", last_res, state, lock);
    end
    cyc(0, 1, 0, 0, 0);
    n_tests++;
    if (lt_cnt !== 8'd1 || last_res !== 2'b11) begin
      n_fail++; $display("FAIL basic_idle_hold got lt=%0d res=%b exp lt=1 res=11", lt_cnt, last_res);
    end
  endtask

  task automatic test_lock();
    cyc(0, 0, 0, 0, 1);
    for (int i = 1; i <= 4; i++) begin
      cyc(1, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 0);
      n_tests++;
      if (lock !== (i == 4) || state !== ((i == 4) ? 2'b10 : 2'b01)) begin
        n_fail++; $display("FAIL lock_eq%0d got lock=%b st=%b exp lock=%b", i, lock, state, (i == 4));
      end
    end
    cyc(1, 0, 1, 0, 0);
    n_tests++;
    if (lock !== 1'b1 || state !== 2'b10 || eq_cnt !== 8'd5) begin
      n_fail++; $display("FAIL lock_stay got lock=%b st=%b eq=%0d exp 1/10/5", lock, state, eq_cnt);
    end
    cyc(1, 0, 0, 1, 0);
    n_tests++;
    if (lock !== 1'b0 || state !== 2'b01 || last_res !== 2'b11) begin
      n_fail++; $display("FAIL lock_release got lock=%b st=%b res=%b exp 0/01/11", lock, state, last_res);
    end
  endtask

  task automatic test_streak_break();
    logic [4:0] seq_eq;
    seq_eq = 5'b11101;  // issued MSB first: eq, eq, eq, lt, eq
    cyc(0, 0, 0, 0, 1);
    for (int i = 4; i >= 0; i--) begin
      cyc(1, ~seq_eq[i], seq_eq[i], 0, 0);
      n_tests++;
      if (lock !== 1'b0 || state !== 2'b01) begin
        n_fail++; $display("FAIL streak_step%0d got lock=%b st=%b exp 0/01", 4 - i, lock, state);
      end
    end
    n_tests++;
    if (eq_cnt !== 8'd4 || lt_cnt !== 8'd1 || last_res !== 2'b10) begin
      n_fail++; $display("FAIL streak_counts got eq=%0d lt=%0d res=%b exp 4/1/10", eq_cnt, lt_cnt, last_res);
    end
  endtask

  task automatic test_error();
    cyc(0, 0, 0, 0, 1);
    cyc(1, 0, 0, 1, 0);
    cyc(1, 1, 0, 1, 0);
    n_tests++;
    if (err_cnt !== 8'd1 || state !== 2'b11 || err_flag !== 1'b1 || last_res !== 2'b11) begin
      n_fail++; $display("FAIL err_enter got err=%0d st=%b ef=%b res=%b exp 1/11/1/11", err_cnt, state, err_flag, last_res);
    end
    for (int i = 0; i < 5; i++) cyc(1, 0, 1, 0, 0);
    n_tests++;
    if (eq_cnt !== 8'd5 || state !== 2'b11 || lock !== 1'b0 || last_res !== 2'b10) begin
      n_fail++; $display("FAIL err_sticky got eq=%0d st=%b lock=%b res=%b exp 5/11/0/10", eq_cnt, state, lock, last_res);
    end
    cyc(1, 0, 0, 0, 0);
    n_tests++;
    if (err_cnt !== 8'd2 || eq_cnt !== 8'd5) begin
      n_fail++; $display("FAIL err_noflag got err=%0d eq=%0d exp 2/5", err_cnt, eq_cnt);
    end
    cyc(0, 0, 0, 0, 1);
    n_tests++;
    if ({lt_cnt, eq_cnt, gt_cnt, err_cnt} !== 32'h0 || {last_res, state, lock, err_flag} !== 6'b0) begin
      n_fail++; $display("FAIL err_clr got cnts=%h st=%b exp 0", {lt_cnt, eq_cnt, gt_cnt, err_cnt}, {last_res, state, lock, err_flag});
    end
    // After clearing, the streak starts fresh: four eq must lock again.
    for (int i = 0; i < 4; i++) cyc(1, 0, 1, 0, 0);
    n_tests++;
    if (lock !== 1'b1 || state !== 2'b10) begin
      n_fail++; $display("FAIL err_relock got lock=%b st=%b exp 1/10", lock, state);
    end
  endtask

  task automatic test_saturation();
    cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 255; i++) cyc(1, 1, 0, 0, 0);
    n_tests++;
    if (lt_cnt !== 8'd255) begin
      n_fail++; $display("FAIL sat_255 got %0d exp 255", lt_cnt);
    end
    cyc(1, 1, 0, 0, 0);
    n_tests++;
    if (lt_cnt !== 8'd255) begin
      n_fail++; $display("FAIL sat_256 got %0d exp 255", lt_cnt);
    end
    cyc(1, 1, 0, 0, 0);
    n_tests++;
    if (lt_cnt !== 8'd255 || state !== 2'b01 || last_res !== 2'b01 || eq_cnt !== 8'd0) begin
      n_fail++; $display("FAIL sat_257 got lt=%0d st=%b res=%b eq=%0d exp 255/01/01/0", lt_cnt, state, last_res, eq_cnt);
    end
  endtask

  task automatic test_clr_priority();
    cyc(0, 0, 0, 0, 1);
    cyc(1, 0, 0, 1, 0);
    cyc(1, 0, 1, 0, 1);
    n_tests++;
    if ({lt_cnt, eq_cnt, gt_cnt, err_cnt} !== 32'h0 || state !== 2'b00 || last_res !== 2'b00) begin
      n_fail++; $display("FAIL clr_wins got cnts=%h st=%b res=%b exp 0/00/00", {lt_cnt, eq_cnt, gt_cnt, err_cnt}, state, last_res);
    end
  endtask

  task automatic test_async_reset();
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 1, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({lt_cnt, err_cnt} !== 16'h0 || state !== 2'b00 || err_flag !== 1'b0 || last_res !== 2'b00) begin
      n_fail++; $display("FAIL async_rst got lt=%0d err=%0d st=%b ef=%b exp 0", lt_cnt, err_cnt, state, err_flag);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 0, 1, 0, 0);
    n_tests++;
    if (eq_cnt !== 8'd1 || state !== 2'b01 || last_res !== 2'b10) begin
      n_fail++; $display("FAIL rst_first_sample got eq=%0d st=%b res=%b exp 1/01/10", eq_cnt, state, last_res);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_basic();
    test_lock();
    test_streak_break();
    test_error();
    test_saturation();
    test_clr_priority();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
